// File: rtl/alu_issue_if.sv
// Handshake bundle between the issue unit and its producer/consumer:
// an operation channel in, a result channel out.
interface alu_issue_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic [3:0]  in_cmd;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_err;

  // valid/ready: a transfer happens at a rising edge where both are 1;
  // the sender holds payload and valid stable until that edge.
  modport master (
    output in_valid, in_a, in_b, in_cmd, out_ready,
    input  in_ready, out_valid, out_data, out_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cmd, out_ready,
    output in_ready, out_valid, out_data, out_err
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Upstream stage of the 8-bit ALU: operation FIFO, registered issue stage
// driving the ALU, and a result register drained over valid/ready.
module alu_issue_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_y,
  output logic [15:0] op_count,
  output logic        issue_state
);

  typedef enum logic {IDLE = 1'b0, LOADED = 1'b1} state_t;

  localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
  localparam logic [3:0]  CMD_DIV = 4'b0101;

  logic [19:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t state;
  state_t state_next;

  logic push;
  logic pop;
  logic capture;
  logic free;
  logic empty;
  logic div_zero;

  logic        out_valid_r;
  logic [15:0] out_data_r;
  logic        out_err_r;

  assign empty        = (count == '0);
  assign free         = !out_valid_r || bus.out_ready;
  // Depends only on occupancy, so a full FIFO refuses even when popping.
  assign bus.in_ready = (count < FULL);
  assign push         = bus.in_valid && bus.in_ready;
  assign div_zero     = (alu_cmd == CMD_DIV) && (alu_b == 8'h00);

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_err   = out_err_r;
  assign issue_state   = state;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    capture    = 1'b0;
    alu_oe     = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = LOADED;
        end
      end
      LOADED: begin
        alu_oe = 1'b1;
        if (free) begin
          capture = 1'b1;
          if (!empty) pop = 1'b1;
          else        state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Storage needs no reset: pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_cmd};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Issue registers keep their last operands while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_cmd <= '0;
    end else if (pop) begin
      {alu_a, alu_b, alu_cmd} <= mem[rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_err_r   <= 1'b0;
    end else if (capture) begin
      out_valid_r <= 1'b1;
      out_data_r  <= div_zero ? 16'hFFFF : alu_y;
      out_err_r   <= div_zero;
    end else if (out_valid_r && bus.out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              op_count <= '0;
    else if (out_valid_r && bus.out_ready) op_count <= op_count + 16'd1;
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit: vector table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_alu_issue_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [3:0]  alu_cmd;
  logic        alu_oe;
  logic [15:0] alu_y;
  logic [15:0] op_count;
  logic        issue_state;

  alu_issue_if bus ();

  alu_issue_unit #(.DEPTH(4), .AW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_cmd     (alu_cmd),
    .alu_oe      (alu_oe),
    .alu_y       (alu_y),
    .op_count    (op_count),
    .issue_state (issue_state)
  );

  always #5 clk = ~clk;

  // Bench ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 6 SHL, 7 SHR, else BUF.
  function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                         input logic [3:0] cmd);
    case (cmd)
      4'd0: return 16'(a) + 16'(b);
      4'd1: return 16'(a) - 16'(b);
      4'd2: return {8'h00, a & b};
      4'd3: return {8'h00, a | b};
      4'd4: return 16'(a) * 16'(b);
      4'd5: return (b == 8'h00) ? 16'hDEAD : {8'h00, a / b};
      4'd6: return 16'(a) << 1;
      4'd7: return {8'h00, a >> 1};
      default: return {8'h00, a};
    endcase
  endfunction

  assign alu_y = alu_oe ? alu_fn(alu_a, alu_b, alu_cmd) : 16'h0000;

  // Reference result {err, data} for an accepted operation.
  function automatic logic [16:0] ref_result(input logic [7:0] a, input logic [7:0] b,
                                             input logic [3:0] cmd);
    if (cmd == 4'd5 && b == 8'h00) return {1'b1, 16'hFFFF};
    return {1'b0, alu_fn(a, b, cmd)};
  endfunction

  int tests = 0;
  int fails = 0;
  logic [16:0] exp_q[$];
  logic [15:0] model_cnt = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Handshakes seen at a falling edge complete at the following rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(ref_result(bus.in_a, bus.in_b, bus.in_cmd));
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_result", {15'h0, bus.out_err, bus.out_data}, 32'h0);
        end else begin
          check("sb_result", {15'h0, bus.out_err, bus.out_data}, {15'h0, exp_q.pop_front()});
        end
        check("sb_op_count", op_count, model_cnt);
        model_cnt = model_cnt + 16'd1;
      end
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [3:0]  cmd;
    logic [15:0] y;
    logic        err;
  } vec_t;

  vec_t vecs[12];

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    model_cnt = 16'h0000;
  endtask

  task automatic drain(input int budget);
    int i;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0 && !bus.out_valid) break;
    end
    check("drain_timeout", (i < budget) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  s_a;
    logic [7:0]  s_b;
    logic [3:0]  s_cmd;
    logic [15:0] s_data;
    int acc;
    int nv;

    vecs[0]  = '{8'd20,  8'd30,  4'd0, 16'd50,   1'b0};
    vecs[1]  = '{8'd25,  8'd15,  4'd0, 16'd40,   1'b0};
    vecs[2]  = '{8'd15,  8'd15,  4'd4, 16'd225,  1'b0};
    vecs[3]  = '{8'd9,   8'd1,   4'd6, 16'd18,   1'b0};
    vecs[4]  = '{8'd8,   8'd0,   4'd5, 16'hFFFF, 1'b1};
    vecs[5]  = '{8'd8,   8'd2,   4'd5, 16'd4,    1'b0};
    vecs[6]  = '{8'd200, 8'd100, 4'd0, 16'd300,  1'b0};
    vecs[7]  = '{8'd3,   8'd10,  4'd1, 16'hFFF9, 1'b0};
    vecs[8]  = '{8'd255, 8'd255, 4'd4, 16'hFE01, 1'b0};
    vecs[9]  = '{8'd0,   8'd0,   4'd5, 16'hFFFF, 1'b1};
    vecs[10] = '{8'hAA,  8'h0F,  4'd2, 16'h000A, 1'b0};
    vecs[11] = '{8'd77,  8'd5,   4'd15, 16'd77,  1'b0};

    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_cmd = '0;
    bus.out_ready = 1'b0;
    do_reset();

    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_alu_oe", alu_oe, 0);
    check("rst_alu_regs", {alu_a, alu_b, alu_cmd}, 0);
    check("rst_out", {bus.out_valid, bus.out_err, bus.out_data}, 0);
    check("rst_op_count", op_count, 0);

    // Single operations through an empty pipeline: latency and values.
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.in_a = vecs[i].a;
      bus.in_b = vecs[i].b;
      bus.in_cmd = vecs[i].cmd;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      check("vec_idle_after_push", alu_oe, 0);
      @(negedge clk);
      check("vec_alu_oe", alu_oe, 1);
      check("vec_alu_regs", {alu_a, alu_b, alu_cmd}, {vecs[i].a, vecs[i].b, vecs[i].cmd});
      check("vec_no_result_yet", bus.out_valid, 0);
      @(negedge clk);
      check("vec_out_valid", bus.out_valid, 1);
      check("vec_out_data", bus.out_data, vecs[i].y);
      check("vec_out_err", bus.out_err, vecs[i].err);
      @(negedge clk);
      check("vec_out_drained", bus.out_valid, 0);
      check("vec_op_count", op_count, i + 1);
      check("vec_alu_oe_idle", alu_oe, 0);
    end

    // Back-to-back issue without bubbles.
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    {bus.in_a, bus.in_b, bus.in_cmd} = {8'd25, 8'd15, 4'd0};
    @(posedge clk);
    #1 {bus.in_a, bus.in_b, bus.in_cmd} = {8'd15, 8'd15, 4'd4};
    @(posedge clk);
    #1 {bus.in_a, bus.in_b, bus.in_cmd} = {8'd9, 8'd1, 4'd6};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    check("b2b_first", {bus.out_valid, bus.out_data}, {1'b1, 16'd40});
    @(negedge clk);
    check("b2b_second", {bus.out_valid, bus.out_data}, {1'b1, 16'd225});
    @(negedge clk);
    check("b2b_third", {bus.out_valid, bus.out_data}, {1'b1, 16'd18});
    drain(20);

    // Backpressure: capacity is FIFO + issue + result.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      bus.in_a = 8'($urandom_range(0, 255));
      bus.in_b = 8'($urandom_range(1, 255));
      bus.in_cmd = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (bus.in_ready) acc++;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("bp_accepted", acc, 6);
    @(negedge clk);
    check("bp_in_ready_low", bus.in_ready, 0);
    s_a = alu_a;
    s_b = alu_b;
    s_cmd = alu_cmd;
    s_data = bus.out_data;
    repeat (3) @(negedge clk);
    check("bp_alu_stable", {alu_a, alu_b, alu_cmd, alu_oe}, {s_a, s_b, s_cmd, 1'b1});
    check("bp_out_stable", {bus.out_valid, bus.out_data}, {1'b1, s_data});
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    nv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("bp_ready_before_pop", bus.in_ready, 0);
      if (c == 1) check("bp_ready_after_pop", bus.in_ready, 1);
      if (bus.out_valid) nv++;
    end
    check("bp_drain_no_bubbles", nv, 6);
    @(negedge clk);
    check("bp_drain_done", bus.out_valid, 0);
    drain(20);

    // Asynchronous reset mid-cycle with operations in flight.
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      {bus.in_a, bus.in_b, bus.in_cmd} = {8'd10 + 8'(c), 8'd3, 4'd0};
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_alu", {alu_oe, alu_a, alu_b, alu_cmd}, 0);
    check("arst_out", {bus.out_valid, bus.out_err, bus.out_data}, 0);
    check("arst_op_count", op_count, 0);
    check("arst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    model_cnt = 16'h0000;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    nv = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid || alu_oe) nv++;
    end
    check("arst_no_stale", nv, 0);

    // Randomized traffic against the queue model.
    for (int c = 0; c < 600; c++) begin
      @(posedge clk);
      #1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_a = 8'($urandom_range(0, 255));
      bus.in_b = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
      bus.in_cmd = 4'($urandom_range(0, 15));
      bus.out_ready = ($urandom_range(0, 2) != 0);
    end
    drain(50);
    check("rand_queue_empty", exp_q.size(), 0);

    // op_count wrap from all ones.
    @(posedge clk);
    #1 force dut.op_count = 16'hFFFF;
    #1 release dut.op_count;
    model_cnt = 16'hFFFF;
    check("wrap_preload", op_count, 16'hFFFF);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    {bus.in_a, bus.in_b, bus.in_cmd} = {8'd20, 8'd30, 4'd0};
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    drain(20);
    check("wrap_op_count", op_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Upstream stage of the 8-bit ALU.
- Accepts operations (a, b, command) over a valid/ready handshake and buffers them in a small FIFO.
- Issues one operation per cycle from a registered issue stage onto the ALU's a/b/command/oe inputs.
- Captures the ALU's combinational 16-bit y into a result register, which downstream logic drains over a second valid/ready handshake.

Parameters:
- DEPTH, 4, input FIFO entries (power of 2, ≥2).
- AW, 2, FIFO pointer width, log2(DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operation offered.
- in_ready  output  1  FIFO can accept; equals (fifo_count < DEPTH).
- in_a  input  8  operand a.
- in_b  input  8  operand b.
- in_cmd  input  4  ALU opcode (ADD=0000 … BUF=1111).
- alu_a  output  8  to ALU a, registered.
- alu_b  output  8  to ALU b, registered.
- alu_cmd  output  4  to ALU command, registered.
- alu_oe  output  1  to ALU oe; 1 exactly while the issue stage holds a valid op.
- alu_y  input  16  ALU result, combinational from alu_a/alu_b/alu_cmd/alu_oe.
- out_valid  output  1  result register holds a result.
- out_ready  input  1  downstream takes the result.
- out_data  output  16  captured result.
- out_err  output  1  result flagged: DIV with b==0.
- op_count  output  16  results delivered (out_valid && out_ready), wraps at 16'hFFFF→0.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FIFO emptied, pointers 0.
  - Issue stage invalid.
  - alu_a/alu_b/alu_cmd = 0, alu_oe = 0.
  - out_valid = 0, out_data = 0, out_err = 0, op_count = 0.
  - In-flight operations are discarded, not replayed.
- Push: in_valid && in_ready at an edge writes {in_a, in_b, in_cmd} to the FIFO tail.
  - in_ready never depends combinationally on out_ready.
  - A full FIFO does not accept a push even if a pop occurs the same cycle.
- Issue stage states:
  - IDLE: issue invalid, alu_oe = 0.
  - LOADED: issue valid, alu_oe = 1.
- Result register free condition: free = !out_valid || out_ready.
- Issue stage transitions at each edge:
  - LOADED && free: alu_y captured into out_data; out_err set; out_valid = 1. Then:
    - FIFO non-empty → pop head into issue regs, stay LOADED.
    - FIFO empty → go IDLE.
  - LOADED && !free: hold everything; alu_* stable; no pop.
  - IDLE && FIFO non-empty: pop head into issue regs → LOADED.
  - IDLE && FIFO empty: alu_a/alu_b/alu_cmd hold their last values; alu_oe = 0.
- Result register:
  - out_valid && out_ready with no new capture → out_valid = 0.
  - out_data/out_err hold while out_valid && !out_ready.
- No FIFO bypass. Latency: push at edge k → LOADED at k+1 → out_valid at k+2 (empty pipeline).
- Throughput: 1 op/cycle while out_ready = 1 and the FIFO is fed.
- Simultaneous push and pop on a non-full FIFO: count unchanged; both take effect.
- Pointers wrap modulo DEPTH.
- Capacity: DEPTH+2 operations outstanding (FIFO + issue + result).
- Error rule: alu_cmd == DIV (0101) && alu_b == 0 → out_data = 16'hFFFF, out_err = 1, alu_y ignored. Otherwise out_data = alu_y, out_err = 0.
- Any unknown/X on alu_y is passed through unchecked; opcode legality is the ALU's responsibility.

Test Plan:
- After reset, push (a=20, b=30, ADD) with out_ready=1:
  - alu_oe=1, alu_a=20, alu_b=30 one cycle after the push edge.
  - out_valid=1, out_data=50 two cycles after; op_count=1 after drain.
- Back-to-back (25,15,ADD), (15,15,MUL), (9,1,SHL?) → out_data sequence 40, 225, then the ALU's SHL result for a=9.
  - Consecutive out_valid cycles; no bubbles with out_ready held 1.
- (8, 0, DIV) → out_data=16'hFFFF, out_err=1. Following (8, 2, DIV) → out_data=4, out_err=0.
- Backpressure: out_ready=0, push continuously:
  - Exactly 6 ops accepted, then in_ready=0.
  - alu_* and out_data stable.
  - Raise out_ready: results drain in push order, one per cycle; in_ready returns 1 the cycle after the first pop.
- Reset asserted asynchronously mid-clock with 3 ops queued:
  - All outputs zero immediately, in_ready=1, op_count=0.
  - No stale result appears after reset release.
- op_count wrap: preload via 65536 drained results (or force 16'hFFFF) → next delivered result gives op_count=0.
